// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
//
// Bus initiator that copies a block of 32-bit words from a source address to a
// destination address over the data-RAM port (ce/we/addr/sel/data). It sits
// beside the CPU, and an external arbiter gives it the RAM port while busy=1.
// The RAM returns read data combinationally in the same cycle as ce=1/we=0 and
// commits writes at the clock edge when ce=1/we=1.
//
// Each word takes one READ cycle followed by one WRITE cycle. When the
// destination overlaps the tail of the source (dst above src but inside the
// source block), the copy runs from the highest word downwards so that no
// source word is overwritten before it has been read.
//
// Optional feature, enabled by the macro MEM_COPY_DMA_FILL_EN:
//   adds fill/fill_word. A start with fill=1 skips READ and writes fill_word to
//   len consecutive ascending destination words, one per cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle request, sampled only in IDLE
//   abort                 cancels an active transfer (READ/WRITE only)
//   src_addr, dst_addr    byte addresses; bits [1:0] are ignored
//   len                   number of 32-bit words to copy
//   fill, fill_word       (MEM_COPY_DMA_FILL_EN only) fill request and pattern
//   busy                  high from the cycle after start until DONE is left
//   done                  one-cycle pulse in the DONE state
//   words_left            words not yet written
//   ram_ce, ram_we        RAM chip enable / write enable
//   ram_addr, ram_sel     RAM byte address / byte lanes
//   ram_data_o            write data to the RAM
//   ram_data_i            read data from the RAM
// -----------------------------------------------------------------------------
module mem_copy_dma #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       fill_word,
`endif
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_left,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i
);

    // Wide enough that src + 4*len can never wrap in the overlap test.
    localparam int                EXT_W     = ADDR_W + LEN_W + 2;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [31:0]       data_q, data_d;
    logic              desc_q, desc_d;
    logic              fill_q, fill_d;

    // Fill request as seen at start; tied off in the copy-only build.
    logic        start_fill;
    logic [31:0] start_fill_word;
`ifdef MEM_COPY_DMA_FILL_EN
    assign start_fill      = fill;
    assign start_fill_word = fill_word;
`else
    assign start_fill      = 1'b0;
    assign start_fill_word = '0;
`endif

    // Start-time decode: word-aligned addresses, overlap test, last-word offset.
    logic [ADDR_W-1:0] src_al, dst_al, last_off;
    logic [EXT_W-1:0]  src_ext, dst_ext, span_ext;
    logic [LEN_W-1:0]  len_m1;
    logic              overlap_fwd;

    assign src_al      = src_addr & WORD_MASK;
    assign dst_al      = dst_addr & WORD_MASK;
    assign src_ext     = EXT_W'(src_al);
    assign dst_ext     = EXT_W'(dst_al);
    assign span_ext    = EXT_W'({len, 2'b00});
    assign len_m1      = len - LEN_W'(1);
    assign last_off    = ADDR_W'({len_m1, 2'b00});
    assign overlap_fwd = (dst_ext > src_ext) && (dst_ext < src_ext + span_ext);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        words_left_d = words_left_q;
        data_d       = data_q;
        desc_d       = desc_q;
        fill_d       = fill_q;
        ram_ce       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_sel      = 4'b0000;
        ram_data_o   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_left_d = len;
                    fill_d       = start_fill;
                    // Fill mode writes data_q without ever reading, so preload it.
                    data_d       = start_fill_word;
                    desc_d       = overlap_fwd && !start_fill;
                    if (overlap_fwd && !start_fill) begin
                        src_ptr_d = src_al + last_off;
                        dst_ptr_d = dst_al + last_off;
                    end else begin
                        src_ptr_d = src_al;
                        dst_ptr_d = dst_al;
                    end
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (start_fill) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                ram_ce   = 1'b1;
                ram_sel  = 4'b1111;
                ram_addr = src_ptr_q;
                data_d   = ram_data_i;
                state_d  = abort ? S_IDLE : S_WRITE;
            end

            S_WRITE: begin
                ram_ce       = 1'b1;
                ram_we       = 1'b1;
                ram_sel      = 4'b1111;
                ram_addr     = dst_ptr_q;
                ram_data_o   = data_q;
                // The write commits this edge even if abort is high.
                words_left_d = words_left_q - LEN_W'(1);
                src_ptr_d    = desc_q ? src_ptr_q - WORD_STEP : src_ptr_q + WORD_STEP;
                dst_ptr_d    = desc_q ? dst_ptr_q - WORD_STEP : dst_ptr_q + WORD_STEP;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (words_left_q > LEN_W'(1)) begin
                    state_d = fill_q ? S_WRITE : S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            words_left_q <= '0;
            data_q       <= '0;
            desc_q       <= 1'b0;
            fill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            words_left_q <= words_left_d;
            data_q       <= data_d;
            desc_q       <= desc_d;
            fill_q       <= fill_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign words_left = words_left_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
`ifdef MEM_COPY_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_word;
`endif
    logic        busy;
    logic        done;
    logic [15:0] words_left;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    always #5 clk = ~clk;

    mem_copy_dma dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
`ifdef MEM_COPY_DMA_FILL_EN
        .fill       (fill),
        .fill_word  (fill_word),
`endif
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    // 4 KiB RAM; addresses alias modulo 4 KiB, which matches 2^32 wrap on low bits.
    logic [31:0] mem  [1024];
    logic [31:0] expm [1024];
    assign ram_data_i = mem[ram_addr[11:2]];

    int          checks = 0;
    int          errors = 0;
    int          acc_rd, acc_wr, acc_bad;
    logic [31:0] first_wr;
    bit          have_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe one cycle of RAM traffic (called away from the edge); writes are
    // committed here, which is what the RAM does at the coming edge.
    task automatic sample_bus();
        if (ram_ce === 1'b1) begin
            if (ram_sel !== 4'hF) acc_bad++;
            if (ram_we === 1'b1) begin
                if (!have_wr) begin
                    first_wr = ram_addr;
                    have_wr  = 1'b1;
                end
                acc_wr++;
                mem[ram_addr[11:2]] = ram_data_o;
            end else begin
                acc_rd++;
            end
        end else if ({ram_we, ram_sel, ram_addr, ram_data_o} !== '0) begin
            acc_bad++;
        end
    endtask

    // Reference: memmove of n words (or fill) computed from the pre-transfer RAM.
    function automatic void model(input logic [31:0] s, input logic [31:0] d, input int n,
                                  input bit f, input logic [31:0] fw);
        for (int i = 0; i < 1024; i++) expm[i] = mem[i];
        for (int i = 0; i < n; i++)
            expm[((d >> 2) + i) & 1023] = f ? fw : mem[((s >> 2) + i) & 1023];
    endfunction

    function automatic logic [31:0] exp_first_wr(input logic [31:0] s, input logic [31:0] d,
                                                 input int n, input bit f);
        longint unsigned sa, da, r;
        sa = longint'(s & 32'hFFFF_FFFC);
        da = longint'(d & 32'hFFFF_FFFC);
        if (!f && da > sa && da < sa + 4 * longint'(n)) r = da + 4 * longint'(n - 1);
        else r = da;
        return r[31:0];
    endfunction

    function automatic int mem_diffs();
        int k = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== expm[i]) k++;
        return k;
    endfunction

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input bit f, input logic [31:0] fw, input int abort_cyc,
                       output int done_cyc, output int end_cyc);
        acc_rd = 0; acc_wr = 0; acc_bad = 0; have_wr = 1'b0; first_wr = '0;
        done_cyc = -1; end_cyc = -1;
        @(negedge clk);
        sample_bus();
        src_addr = s;
        dst_addr = d;
        len      = 16'(n);
        start    = 1'b1;
`ifdef MEM_COPY_DMA_FILL_EN
        fill      = f;
        fill_word = fw;
`endif
        @(posedge clk);  // start accepted at this edge (T0)
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == abort_cyc);
            sample_bus();
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (busy !== 1'b1) begin
                end_cyc = c;
                break;
            end
        end
        abort = 1'b0;
        chk("timeout", end_cyc < 0, 0);
    endtask

    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit f, input logic [31:0] fw);
        int dc, ec;
        model(s, d, n, f, fw);
        run(s, d, n, f, fw, 0, dc, ec);
        chk("done_cycle", dc, f ? n + 1 : 2 * n + 1);
        chk("end_cycle", ec, f ? n + 2 : 2 * n + 2);
        chk("reads", acc_rd, f ? 0 : n);
        chk("writes", acc_wr, n);
        chk("bus_sel", acc_bad, 0);
        chk("mem", mem_diffs(), 0);
        chk("words_left", words_left, 0);
        if (n > 0) chk("first_wr_addr", first_wr, exp_first_wr(s, d, n, f));
    endtask

    initial begin
        int          dc, ec;
        logic [31:0] s, d;
        int          n;
        bit          f;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
`ifdef MEM_COPY_DMA_FILL_EN
        fill = 1'b0; fill_word = '0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words_left", words_left, 0);
        chk("rst_ce", ram_ce, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_sel", ram_sel, 0);
        chk("rst_data", ram_data_o, 0);
        rst = 1'b0;

        // Basic copy.
        mem[32'h100 >> 2] = 32'hAAAA_0001; mem[32'h104 >> 2] = 32'hBBBB_0002;
        mem[32'h108 >> 2] = 32'hCCCC_0003; mem[32'h10C >> 2] = 32'hDDDD_0004;
        do_copy(32'h100, 32'h200, 4, 1'b0, '0);

        // Overlapping forward copy must run descending.
        for (int i = 0; i < 4; i++) mem[(32'h100 >> 2) + i] = 32'(i + 1);
        do_copy(32'h100, 32'h104, 4, 1'b0, '0);
        chk("overlap_first_wr", first_wr, 32'h110);
        chk("overlap_word0", mem[32'h104 >> 2], 32'd1);
        chk("overlap_word3", mem[32'h110 >> 2], 32'd4);

        // Overlapping backward copy, src==dst, zero length, low bits ignored, wrap.
        do_copy(32'h104, 32'h100, 4, 1'b0, '0);
        do_copy(32'h240, 32'h240, 3, 1'b0, '0);
        do_copy(32'h300, 32'h380, 0, 1'b0, '0);
        do_copy(32'h123, 32'h2C2, 5, 1'b0, '0);
        do_copy(32'hFFFF_FFF8, 32'h500, 3, 1'b0, '0);

        // Abort during the 3rd WRITE (cycle 6 after T0).
        model(32'h100, 32'h400, 3, 1'b0, '0);
        run(32'h100, 32'h400, 8, 1'b0, '0, 6, dc, ec);
        chk("abort_done", dc, -1);
        chk("abort_end", ec, 7);
        chk("abort_writes", acc_wr, 3);
        chk("abort_words_left", words_left, 5);
        chk("abort_mem", mem_diffs(), 0);
        do_copy(32'h100, 32'h400, 2, 1'b0, '0);

        // Reset during READ; start/abort held during reset have no effect.
        model(32'h100, 32'h600, 0, 1'b0, '0);
        run(32'h100, 32'h600, 4, 1'b0, '0, -1, dc, ec);
        chk("rst_mid_end", ec, 10);
        for (int i = 0; i < 4; i++) mem[(32'h600 >> 2) + i] = expm[(32'h600 >> 2) + i];
        acc_wr = 0;
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h600; len = 16'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid_in_read", {ram_ce, ram_we}, 2'b10);
        sample_bus();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sample_bus();
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_ce", ram_ce, 0);
            chk("rst_mid_words_left", words_left, 0);
            chk("rst_mid_addr", ram_addr, 0);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        sample_bus();
        chk("rst_mid_idle", busy, 0);
        chk("rst_mid_no_write", acc_wr, 0);
        chk("rst_mid_mem", mem_diffs(), 0);

`ifdef MEM_COPY_DMA_FILL_EN
        do_copy(32'h0, 32'h300, 3, 1'b1, 32'hDEAD_BEEF);
        chk("fill_word2", mem[32'h308 >> 2], 32'hDEAD_BEEF);
`endif

        // Randomized transfers against the memmove/fill model.
        for (int t = 0; t < 30; t++) begin
            s = ($urandom_range(0, 240) << 2) | $urandom_range(0, 3);
            d = ($urandom_range(0, 240) << 2) | $urandom_range(0, 3);
            n = $urandom_range(0, 16);
            f = 1'b0;
`ifdef MEM_COPY_DMA_FILL_EN
            f = ($urandom_range(0, 3) == 0);
`endif
            do_copy(s, d, n, f, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
